// File: rtl/axi4_lite_Defs.sv
// rtl/axi4_lite_Defs.sv - shared AXI4-Lite widths, response codes and arbiter FSM state types
package axi4_lite_Defs;

    localparam int Addr_Width = 32;
    localparam int Data_Width = 32;
    localparam int Strb_Width = Data_Width / 8;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first requester at or after ptr
module rr_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       ptr,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [IDX_W-1:0]       idx
);

    always_comb begin
        logic found;
        int   cand;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_MASTERS) begin
                cand = cand - NUM_MASTERS;
            end
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/axi4_lite_arbiter.sv
// rtl/axi4_lite_arbiter.sv - shares one AXI4-Lite slave among NUM_MASTERS masters
// with independent round-robin read and write arbitration, one outstanding transaction per path.
module axi4_lite_arbiter
    import axi4_lite_Defs::*;
#(
    parameter  int NUM_MASTERS = 2,
    localparam int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [NUM_MASTERS*Addr_Width-1:0] M_AWADDR,
    input  logic [NUM_MASTERS-1:0]            M_AWVALID,
    output logic [NUM_MASTERS-1:0]            M_AWREADY,
    input  logic [NUM_MASTERS*Data_Width-1:0] M_WDATA,
    input  logic [NUM_MASTERS*Strb_Width-1:0] M_WSTRB,
    input  logic [NUM_MASTERS-1:0]            M_WVALID,
    output logic [NUM_MASTERS-1:0]            M_WREADY,
    output logic [1:0]                        M_BRESP,
    output logic [NUM_MASTERS-1:0]            M_BVALID,
    input  logic [NUM_MASTERS-1:0]            M_BREADY,
    input  logic [NUM_MASTERS*Addr_Width-1:0] M_ARADDR,
    input  logic [NUM_MASTERS-1:0]            M_ARVALID,
    output logic [NUM_MASTERS-1:0]            M_ARREADY,
    output logic [Data_Width-1:0]             M_RDATA,
    output logic [1:0]                        M_RRESP,
    output logic [NUM_MASTERS-1:0]            M_RVALID,
    input  logic [NUM_MASTERS-1:0]            M_RREADY,
    output logic [Addr_Width-1:0]             S_AWADDR,
    output logic                              S_AWVALID,
    input  logic                              S_AWREADY,
    output logic [Data_Width-1:0]             S_WDATA,
    output logic [Strb_Width-1:0]             S_WSTRB,
    output logic                              S_WVALID,
    input  logic                              S_WREADY,
    input  logic [1:0]                        S_BRESP,
    input  logic                              S_BVALID,
    output logic                              S_BREADY,
    output logic [Addr_Width-1:0]             S_ARADDR,
    output logic                              S_ARVALID,
    input  logic                              S_ARREADY,
    input  logic [Data_Width-1:0]             S_RDATA,
    input  logic [1:0]                        S_RRESP,
    input  logic                              S_RVALID,
    output logic                              S_RREADY,
    output logic [NUM_MASTERS-1:0]            wr_grant,
    output logic [NUM_MASTERS-1:0]            rd_grant
);

    function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] g);
        return (int'(g) == NUM_MASTERS - 1) ? '0 : g + 1'b1;
    endfunction

    wr_state_t              wr_state, wr_state_nxt;
    logic [NUM_MASTERS-1:0] wr_grant_nxt, wr_arb_grant;
    logic [IDX_W-1:0]       wr_idx, wr_idx_nxt, wr_ptr, wr_ptr_nxt, wr_arb_idx;
    logic                   aw_done, aw_done_nxt, w_done, w_done_nxt;

    rd_state_t              rd_state, rd_state_nxt;
    logic [NUM_MASTERS-1:0] rd_grant_nxt, rd_arb_grant;
    logic [IDX_W-1:0]       rd_idx, rd_idx_nxt, rd_ptr, rd_ptr_nxt, rd_arb_idx;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    rr_arbiter #(.NUM_MASTERS(NUM_MASTERS), .IDX_W(IDX_W)) u_wr_arb (
        .req   (M_AWVALID),
        .ptr   (wr_ptr),
        .grant (wr_arb_grant),
        .idx   (wr_arb_idx)
    );

    rr_arbiter #(.NUM_MASTERS(NUM_MASTERS), .IDX_W(IDX_W)) u_rd_arb (
        .req   (M_ARVALID),
        .ptr   (rd_ptr),
        .grant (rd_arb_grant),
        .idx   (rd_arb_idx)
    );

    // Payloads follow the registered owner; only VALID/READY need gating.
    assign S_AWADDR = M_AWADDR[wr_idx*Addr_Width +: Addr_Width];
    assign S_WDATA  = M_WDATA[wr_idx*Data_Width +: Data_Width];
    assign S_WSTRB  = M_WSTRB[wr_idx*Strb_Width +: Strb_Width];
    assign S_ARADDR = M_ARADDR[rd_idx*Addr_Width +: Addr_Width];
    assign M_BRESP  = S_BRESP;
    assign M_RDATA  = S_RDATA;
    assign M_RRESP  = S_RRESP;

    assign aw_hs = S_AWVALID & S_AWREADY;
    assign w_hs  = S_WVALID & S_WREADY;
    assign b_hs  = S_BVALID & S_BREADY;
    assign ar_hs = S_ARVALID & S_ARREADY;
    assign r_hs  = S_RVALID & S_RREADY;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_state <= W_IDLE;
            wr_grant <= '0;
            wr_idx   <= '0;
            wr_ptr   <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            rd_state <= R_IDLE;
            rd_grant <= '0;
            rd_idx   <= '0;
            rd_ptr   <= '0;
        end else begin
            wr_state <= wr_state_nxt;
            wr_grant <= wr_grant_nxt;
            wr_idx   <= wr_idx_nxt;
            wr_ptr   <= wr_ptr_nxt;
            aw_done  <= aw_done_nxt;
            w_done   <= w_done_nxt;
            rd_state <= rd_state_nxt;
            rd_grant <= rd_grant_nxt;
            rd_idx   <= rd_idx_nxt;
            rd_ptr   <= rd_ptr_nxt;
        end
    end

    always_comb begin
        wr_state_nxt = wr_state;
        wr_grant_nxt = wr_grant;
        wr_idx_nxt   = wr_idx;
        wr_ptr_nxt   = wr_ptr;
        aw_done_nxt  = aw_done;
        w_done_nxt   = w_done;
        case (wr_state)
            W_IDLE: begin
                if (|M_AWVALID) begin
                    wr_grant_nxt = wr_arb_grant;
                    wr_idx_nxt   = wr_arb_idx;
                    wr_state_nxt = W_ADDR;
                end
            end
            W_ADDR: begin
                if (aw_hs) aw_done_nxt = 1'b1;
                if (w_hs)  w_done_nxt  = 1'b1;
                if ((aw_done | aw_hs) && (w_done | w_hs)) begin
                    wr_state_nxt = W_RESP;
                end
            end
            W_RESP: begin
                if (b_hs) begin
                    wr_ptr_nxt   = ptr_after(wr_idx);
                    wr_grant_nxt = '0;
                    aw_done_nxt  = 1'b0;
                    w_done_nxt   = 1'b0;
                    wr_state_nxt = W_IDLE;
                end
            end
            default: wr_state_nxt = W_IDLE;
        endcase
    end

    // Done flags are registered, so S_*VALID never depends on S_*READY in the same cycle.
    always_comb begin
        S_AWVALID = 1'b0;
        S_WVALID  = 1'b0;
        S_BREADY  = 1'b0;
        M_AWREADY = '0;
        M_WREADY  = '0;
        M_BVALID  = '0;
        if (wr_state == W_ADDR) begin
            S_AWVALID         = M_AWVALID[wr_idx] & ~aw_done;
            S_WVALID          = M_WVALID[wr_idx] & ~w_done;
            M_AWREADY[wr_idx] = S_AWREADY & ~aw_done;
            M_WREADY[wr_idx]  = S_WREADY & ~w_done;
        end
        if (wr_state == W_RESP) begin
            M_BVALID[wr_idx] = S_BVALID;
            S_BREADY         = M_BREADY[wr_idx];
        end
    end

    always_comb begin
        rd_state_nxt = rd_state;
        rd_grant_nxt = rd_grant;
        rd_idx_nxt   = rd_idx;
        rd_ptr_nxt   = rd_ptr;
        case (rd_state)
            R_IDLE: begin
                if (|M_ARVALID) begin
                    rd_grant_nxt = rd_arb_grant;
                    rd_idx_nxt   = rd_arb_idx;
                    rd_state_nxt = R_ADDR;
                end
            end
            R_ADDR: begin
                if (ar_hs) rd_state_nxt = R_DATA;
            end
            R_DATA: begin
                if (r_hs) begin
                    rd_ptr_nxt   = ptr_after(rd_idx);
                    rd_grant_nxt = '0;
                    rd_state_nxt = R_IDLE;
                end
            end
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        S_ARVALID = 1'b0;
        S_RREADY  = 1'b0;
        M_ARREADY = '0;
        M_RVALID  = '0;
        if (rd_state == R_ADDR) begin
            S_ARVALID         = M_ARVALID[rd_idx];
            M_ARREADY[rd_idx] = S_ARREADY;
        end
        if (rd_state == R_DATA) begin
            M_RVALID[rd_idx] = S_RVALID;
            S_RREADY         = M_RREADY[rd_idx];
        end
    end

endmodule

// File: tb/tb_axi4_lite_arbiter.sv
// tb/tb_axi4_lite_arbiter.sv - directed self-checking bench for axi4_lite_arbiter with two masters
`timescale 1ns/1ps
module tb_axi4_lite_arbiter;
    import axi4_lite_Defs::*;

    localparam int N = 2;

    logic                     ACLK = 1'b0;
    logic                     ARESETN;
    logic [N*Addr_Width-1:0]  M_AWADDR, M_ARADDR;
    logic [N-1:0]             M_AWVALID, M_AWREADY, M_WVALID, M_WREADY, M_BVALID, M_BREADY;
    logic [N-1:0]             M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;
    logic [N*Data_Width-1:0]  M_WDATA;
    logic [N*Strb_Width-1:0]  M_WSTRB;
    logic [1:0]               M_BRESP, M_RRESP, S_BRESP, S_RRESP;
    logic [Data_Width-1:0]    M_RDATA, S_WDATA, S_RDATA;
    logic [Addr_Width-1:0]    S_AWADDR, S_ARADDR;
    logic [Strb_Width-1:0]    S_WSTRB;
    logic                     S_AWVALID, S_AWREADY, S_WVALID, S_WREADY, S_BVALID, S_BREADY;
    logic                     S_ARVALID, S_ARREADY, S_RVALID, S_RREADY;
    logic [N-1:0]             wr_grant, rd_grant;

    int errors = 0;
    int checks = 0;
    int w_beats = 0;
    int aw_beats = 0;
    int rv0_count = 0;

    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) begin
        if (S_WVALID && S_WREADY)   w_beats   <= w_beats + 1;
        if (S_AWVALID && S_AWREADY) aw_beats  <= aw_beats + 1;
        if (M_RVALID[0])            rv0_count <= rv0_count + 1;
    end

    axi4_lite_arbiter #(.NUM_MASTERS(N)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
        .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
        .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
        .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
        .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY),
        .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
        .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
        .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
        .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
        .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
        .wr_grant(wr_grant), .rd_grant(rd_grant)
    );

    task automatic clear_inputs;
        M_AWADDR = '0; M_AWVALID = '0; M_WDATA = '0; M_WSTRB = '0; M_WVALID = '0; M_BREADY = '0;
        M_ARADDR = '0; M_ARVALID = '0; M_RREADY = '0;
        S_AWREADY = 1'b1; S_WREADY = 1'b1; S_ARREADY = 1'b1;
        S_BRESP = 2'b11; S_BVALID = 1'b0; S_RDATA = '0; S_RRESP = 2'b11; S_RVALID = 1'b0;
    endtask

    task automatic next_cycle;
        @(posedge ACLK);
        #1;
    endtask

    task automatic serve_read(input logic [31:0] data, input logic [1:0] resp,
                              output logic [N-1:0] gnt, output logic [31:0] addr,
                              output logic [N-1:0] rvalid, output logic [31:0] rdata,
                              output logic [1:0] rresp, output int lat);
        lat = 0;
        @(negedge ACLK);
        while (!S_ARVALID && lat < 20) begin
            @(negedge ACLK);
            lat++;
        end
        gnt  = rd_grant;
        addr = S_ARADDR;
        next_cycle();
        M_ARVALID = M_ARVALID & ~gnt;
        S_RVALID = 1'b1; S_RDATA = data; S_RRESP = resp; M_RREADY = '1;
        @(negedge ACLK);
        rvalid = M_RVALID; rdata = M_RDATA; rresp = M_RRESP;
        next_cycle();
        S_RVALID = 1'b0; M_RREADY = '0;
    endtask

    task automatic test_reset;
        ARESETN = 1'b0;
        clear_inputs();
        M_AWVALID = '1; M_WVALID = '1; M_ARVALID = '1; M_BREADY = '1; M_RREADY = '1;
        S_BVALID = 1'b1; S_RVALID = 1'b1;
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        checks++;
        if ({wr_grant, rd_grant} !== 4'b0000) begin
            errors++; $display("FAIL reset_grants: got %b expected 0000", {wr_grant, rd_grant});
        end
        checks++;
        if ({S_AWVALID, S_WVALID, S_ARVALID, S_BREADY, S_RREADY} !== 5'b0) begin
            errors++; $display("FAIL reset_slave_side: got %b expected 00000", {S_AWVALID, S_WVALID, S_ARVALID, S_BREADY, S_RREADY});
        end
        checks++;
        if ({M_AWREADY, M_WREADY, M_ARREADY, M_BVALID, M_RVALID} !== 10'b0) begin
            errors++; $display("FAIL reset_master_side: got %b expected 0", {M_AWREADY, M_WREADY, M_ARREADY, M_BVALID, M_RVALID});
        end
        clear_inputs();
        next_cycle();
        ARESETN = 1'b1;
    endtask

    task automatic test_single_write;
        M_AWADDR[0 +: 32] = 32'h0000_0010; M_WDATA[0 +: 32] = 32'hDEAD_BEEF; M_WSTRB[0 +: 4] = 4'hF;
        M_AWVALID = 2'b01; M_WVALID = 2'b01;
        @(negedge ACLK);
        checks++;
        if ({S_AWVALID, wr_grant} !== 3'b000) begin
            errors++; $display("FAIL wr_latency_idle: got %b expected 000", {S_AWVALID, wr_grant});
        end
        next_cycle();
        @(negedge ACLK);
        checks++;
        if ({S_AWVALID, S_WVALID, wr_grant, M_AWREADY} !== 6'b11_01_01) begin
            errors++; $display("FAIL wr_forward_ctl: got %b expected 110101", {S_AWVALID, S_WVALID, wr_grant, M_AWREADY});
        end
        checks++;
        if ({S_AWADDR, S_WDATA, S_WSTRB} !== {32'h0000_0010, 32'hDEAD_BEEF, 4'hF}) begin
            errors++; $display("FAIL wr_payload: got %h %h %h expected 00000010 deadbeef f", S_AWADDR, S_WDATA, S_WSTRB);
        end
        next_cycle();
        M_AWVALID = '0; M_WVALID = '0;
        S_BVALID = 1'b1; S_BRESP = OKAY; M_BREADY = 2'b01;
        @(negedge ACLK);
        checks++;
        if ({M_BVALID, M_BRESP, S_BREADY} !== {2'b01, OKAY, 1'b1}) begin
            errors++; $display("FAIL wr_bresp: got %b %b %b expected 01 00 1", M_BVALID, M_BRESP, S_BREADY);
        end
        next_cycle();
        S_BVALID = 1'b0; M_BREADY = '0;
        @(negedge ACLK);
        checks++;
        if ({wr_grant, M_BVALID} !== 4'b0000) begin
            errors++; $display("FAIL wr_release: got %b expected 0000", {wr_grant, M_BVALID});
        end
    endtask

    task automatic test_read_rr;
        logic [N-1:0] gnt, rv;
        logic [31:0]  addr, rdata;
        logic [1:0]   rresp;
        int           lat;
        ARESETN = 1'b0;
        next_cycle();
        ARESETN = 1'b1;
        M_ARADDR = {32'h0000_0200, 32'h0000_0100};
        M_ARVALID = 2'b11;
        serve_read(32'h1111_1111, OKAY, gnt, addr, rv, rdata, rresp, lat);
        checks++;
        if ({gnt, addr, lat} !== {2'b01, 32'h100, 32'd1}) begin
            errors++; $display("FAIL rr_first: got gnt=%b addr=%h lat=%0d expected 01 100 1", gnt, addr, lat);
        end
        checks++;
        if ({rv, rdata} !== {2'b01, 32'h1111_1111}) begin
            errors++; $display("FAIL rr_first_data: got %b %h expected 01 11111111", rv, rdata);
        end
        M_ARVALID = 2'b11;
        serve_read(32'h2222_2222, SLVERR, gnt, addr, rv, rdata, rresp, lat);
        checks++;
        if ({gnt, addr, lat} !== {2'b10, 32'h200, 32'd1}) begin
            errors++; $display("FAIL rr_second: got gnt=%b addr=%h lat=%0d expected 10 200 1", gnt, addr, lat);
        end
        checks++;
        if ({rv, rdata, rresp} !== {2'b10, 32'h2222_2222, SLVERR}) begin
            errors++; $display("FAIL rr_second_data: got %b %h %b expected 10 22222222 10", rv, rdata, rresp);
        end
        M_ARVALID = 2'b11;
        serve_read(32'h3333_3333, OKAY, gnt, addr, rv, rdata, rresp, lat);
        M_ARVALID = '0;
        checks++;
        if ({gnt, lat} !== {2'b01, 32'd1}) begin
            errors++; $display("FAIL rr_wrap: got gnt=%b lat=%0d expected 01 1", gnt, lat);
        end
    endtask

    task automatic test_w_before_aw;
        int aw0, w0;
        aw0 = aw_beats; w0 = w_beats;
        S_AWREADY = 1'b0; M_BREADY = 2'b10;
        M_WDATA[32 +: 32] = 32'hCAFE_0001; M_WSTRB[4 +: 4] = 4'h3; M_WVALID = 2'b10;
        repeat (3) next_cycle();
        checks++;
        if ({S_WVALID, wr_grant} !== 3'b000) begin
            errors++; $display("FAIL wfirst_no_grant: got %b expected 000", {S_WVALID, wr_grant});
        end
        M_AWADDR[32 +: 32] = 32'h0000_0030; M_AWVALID = 2'b10;
        next_cycle();
        @(negedge ACLK);
        checks++;
        if ({wr_grant, S_AWVALID, S_WVALID, S_WDATA, S_WSTRB, S_BREADY} !== {2'b10, 2'b11, 32'hCAFE_0001, 4'h3, 1'b0}) begin
            errors++; $display("FAIL wfirst_grant: got %b %b%b %h %h %b", wr_grant, S_AWVALID, S_WVALID, S_WDATA, S_WSTRB, S_BREADY);
        end
        next_cycle();
        M_WVALID = '0;
        @(negedge ACLK);
        checks++;
        if ({S_AWVALID, M_WREADY, S_BREADY} !== 4'b1_00_0) begin
            errors++; $display("FAIL wfirst_aw_pending: got %b expected 1000", {S_AWVALID, M_WREADY, S_BREADY});
        end
        next_cycle();
        S_AWREADY = 1'b1;
        @(negedge ACLK);
        checks++;
        if ({M_AWREADY, S_AWADDR, S_BREADY} !== {2'b10, 32'h30, 1'b0}) begin
            errors++; $display("FAIL wfirst_aw_ready: got %b %h %b expected 10 30 0", M_AWREADY, S_AWADDR, S_BREADY);
        end
        next_cycle();
        M_AWVALID = '0; S_BVALID = 1'b1; S_BRESP = OKAY;
        @(negedge ACLK);
        checks++;
        if ({S_BREADY, M_BVALID} !== 3'b1_10) begin
            errors++; $display("FAIL wfirst_resp: got %b expected 110", {S_BREADY, M_BVALID});
        end
        next_cycle();
        S_BVALID = 1'b0; M_BREADY = '0;
        @(negedge ACLK);
        checks++;
        if ({wr_grant, w_beats - w0, aw_beats - aw0} !== {2'b00, 32'd1, 32'd1}) begin
            errors++; $display("FAIL wfirst_beats: got grant=%b w=%0d aw=%0d expected 00 1 1", wr_grant, w_beats - w0, aw_beats - aw0);
        end
    endtask

    task automatic test_concurrent;
        int rv0;
        rv0 = rv0_count;
        M_AWADDR[0 +: 32] = 32'h20; M_WDATA[0 +: 32] = 32'h5555_AAAA; M_WSTRB[0 +: 4] = 4'hF;
        M_AWVALID = 2'b01; M_WVALID = 2'b01;
        M_ARADDR[32 +: 32] = 32'h20; M_ARVALID = 2'b10;
        next_cycle();
        @(negedge ACLK);
        checks++;
        if ({wr_grant, rd_grant, S_AWVALID, S_WVALID, S_ARVALID, S_ARADDR} !== {2'b01, 2'b10, 3'b111, 32'h20}) begin
            errors++; $display("FAIL conc_grants: got %b %b %b%b%b %h", wr_grant, rd_grant, S_AWVALID, S_WVALID, S_ARVALID, S_ARADDR);
        end
        next_cycle();
        M_AWVALID = '0; M_WVALID = '0; M_ARVALID = '0;
        S_BVALID = 1'b1; S_BRESP = OKAY; S_RVALID = 1'b1; S_RDATA = 32'h1234_5678; S_RRESP = OKAY;
        M_BREADY = 2'b01; M_RREADY = 2'b11;
        @(negedge ACLK);
        checks++;
        if ({M_BVALID, M_RVALID, M_RDATA} !== {2'b01, 2'b10, 32'h1234_5678}) begin
            errors++; $display("FAIL conc_resp: got %b %b %h expected 01 10 12345678", M_BVALID, M_RVALID, M_RDATA);
        end
        next_cycle();
        S_BVALID = 1'b0; S_RVALID = 1'b0; M_BREADY = '0; M_RREADY = '0;
        @(negedge ACLK);
        checks++;
        if ({wr_grant, rd_grant, rv0_count - rv0} !== {4'b0000, 32'd0}) begin
            errors++; $display("FAIL conc_done: got %b %b rv0=%0d expected 00 00 0", wr_grant, rd_grant, rv0_count - rv0);
        end
    endtask

    task automatic test_reset_mid;
        S_WREADY = 1'b0;
        M_AWADDR[32 +: 32] = 32'h50; M_WDATA[32 +: 32] = 32'h0BAD_F00D; M_AWVALID = 2'b10; M_WVALID = 2'b10;
        next_cycle();
        @(negedge ACLK);
        checks++;
        if (wr_grant !== 2'b10) begin
            errors++; $display("FAIL rstmid_grant: got %b expected 10", wr_grant);
        end
        next_cycle();
        M_AWVALID = '0;
        @(negedge ACLK);
        checks++;
        if ({S_AWVALID, S_WVALID} !== 2'b01) begin
            errors++; $display("FAIL rstmid_w_pending: got %b expected 01", {S_AWVALID, S_WVALID});
        end
        #1;
        ARESETN = 1'b0;
        M_AWADDR[0 +: 32] = 32'h60; M_AWVALID = 2'b11;
        #1;
        checks++;
        if ({wr_grant, rd_grant, S_AWVALID, S_WVALID, S_BREADY, S_ARVALID, S_RREADY} !== 9'b0) begin
            errors++; $display("FAIL rstmid_async: got %b expected 0", {wr_grant, rd_grant, S_AWVALID, S_WVALID, S_BREADY, S_ARVALID, S_RREADY});
        end
        checks++;
        if ({M_AWREADY, M_WREADY, M_BVALID} !== 6'b0) begin
            errors++; $display("FAIL rstmid_master_side: got %b expected 000000", {M_AWREADY, M_WREADY, M_BVALID});
        end
        S_WREADY = 1'b1; M_WVALID = '0;
        next_cycle();
        ARESETN = 1'b1;
        @(negedge ACLK);
        checks++;
        if (wr_grant !== 2'b00) begin
            errors++; $display("FAIL rstmid_release_idle: got %b expected 00", wr_grant);
        end
        next_cycle();
        @(negedge ACLK);
        checks++;
        if ({wr_grant, S_AWADDR} !== {2'b01, 32'h60}) begin
            errors++; $display("FAIL rstmid_first_grant: got %b %h expected 01 60", wr_grant, S_AWADDR);
        end
        #1;
        ARESETN = 1'b0;
        clear_inputs();
        next_cycle();
        ARESETN = 1'b1;
    endtask

    task automatic test_backpressure;
        M_AWADDR[0 +: 32] = 32'h70; M_AWVALID = 2'b01; M_WVALID = 2'b01;
        next_cycle();
        next_cycle();
        M_AWADDR[32 +: 32] = 32'h40; M_AWVALID = 2'b10; M_WVALID = 2'b10;
        S_BVALID = 1'b1; S_BRESP = OKAY; M_BREADY = 2'b00;
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            checks++;
            if ({wr_grant, M_BVALID, S_BREADY, S_AWVALID} !== {2'b01, 2'b01, 1'b0, 1'b0}) begin
                errors++; $display("FAIL bp_hold_%0d: got %b expected 010100", i, {wr_grant, M_BVALID, S_BREADY, S_AWVALID});
            end
            next_cycle();
        end
        M_BREADY = 2'b01;
        @(negedge ACLK);
        checks++;
        if (S_BREADY !== 1'b1) begin
            errors++; $display("FAIL bp_bready: got %b expected 1", S_BREADY);
        end
        next_cycle();
        S_BVALID = 1'b0; M_BREADY = '0;
        @(negedge ACLK);
        checks++;
        if (wr_grant !== 2'b00) begin
            errors++; $display("FAIL bp_idle_gap: got %b expected 00", wr_grant);
        end
        next_cycle();
        @(negedge ACLK);
        checks++;
        if ({wr_grant, S_AWADDR} !== {2'b10, 32'h40}) begin
            errors++; $display("FAIL bp_next_owner: got %b %h expected 10 40", wr_grant, S_AWADDR);
        end
        next_cycle();
        M_AWVALID = '0; M_WVALID = '0; S_BVALID = 1'b1; M_BREADY = 2'b10;
        next_cycle();
        S_BVALID = 1'b0; M_BREADY = '0;
        @(negedge ACLK);
        checks++;
        if (wr_grant !== 2'b00) begin
            errors++; $display("FAIL bp_final_release: got %b expected 00", wr_grant);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        ARESETN = 1'b0;
        clear_inputs();
        test_reset();
        test_single_write();
        test_read_rr();
        test_w_before_aw();
        test_concurrent();
        test_reset_mid();
        test_backpressure();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi4_lite_arbiter.md
Name: axi4_lite_arbiter

Overview:
- Shares one AXI4-Lite slave port among NUM_MASTERS AXI4-Lite masters.
- Read and write paths are arbitrated independently, each with round-robin priority.
- A grant is held from address acceptance until the response handshake completes, so each channel has at most one outstanding transaction.
- Sits between the bus-master agents and the single AXI4-Lite slave/memory block; Addr_Width and Data_Width come from axi4_lite_Defs.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8).
- IDX_W, $clog2(NUM_MASTERS), width of the grant index (derived; not overridden).

Ports:
- ACLK  in  1  single bus clock, rising edge.
- ARESETN  in  1  asynchronous active-low reset.
- M_AWADDR  in  NUM_MASTERS*Addr_Width  per-master write address, master i at slice i.
- M_AWVALID / M_AWREADY  in / out  NUM_MASTERS  write-address handshake per master.
- M_WDATA  in  NUM_MASTERS*Data_Width  per-master write data.
- M_WSTRB  in  NUM_MASTERS*(Data_Width/8)  per-master byte strobes.
- M_WVALID / M_WREADY  in / out  NUM_MASTERS  write-data handshake.
- M_BRESP  out  2  write response, broadcast to all masters.
- M_BVALID / M_BREADY  out / in  NUM_MASTERS  write-response handshake.
- M_ARADDR  in  NUM_MASTERS*Addr_Width  per-master read address.
- M_ARVALID / M_ARREADY  in / out  NUM_MASTERS  read-address handshake.
- M_RDATA  out  Data_Width  read data, broadcast.
- M_RRESP  out  2  read response, broadcast.
- M_RVALID / M_RREADY  out / in  NUM_MASTERS  read-data handshake.
- S_AWADDR, S_AWVALID, S_AWREADY, S_WDATA, S_WSTRB, S_WVALID, S_WREADY, S_BRESP, S_BVALID, S_BREADY, S_ARADDR, S_ARVALID, S_ARREADY, S_RDATA, S_RRESP, S_RVALID, S_RREADY  (slave-side AXI4-Lite, standard directions/widths).
- wr_grant  out  NUM_MASTERS  one-hot current write owner (0 when idle).
- rd_grant  out  NUM_MASTERS  one-hot current read owner (0 when idle).

Behaviour:
- Reset (ARESETN low, asynchronous): both FSMs go to IDLE; wr_grant = rd_grant = 0; round-robin pointers = 0; aw_done/w_done = 0.
  - All S_*VALID, S_BREADY, S_RREADY, M_*READY and M_*VALID are 0 while in reset.
  - A transaction in flight is abandoned; no response is forwarded after reset release.
- Write FSM:
  - W_IDLE:
    - Request vector = M_AWVALID.
    - If non-zero, select the first requester at or after wr_ptr (wrapping modulo NUM_MASTERS).
    - Register the grant and go to W_ADDR.
    - Grant latency: 1 cycle from AWVALID to S_AWVALID.
  - W_ADDR:
    - S_AW* = granted master's AW* and M_AWREADY[g] = S_AWREADY; S_W* = master's W* and M_WREADY[g] = S_WREADY.
    - AW and W are forwarded independently. aw_done/w_done are set on their handshakes, and each channel's VALID is gated off once done.
    - When both are done (same cycle or different cycles), go to W_RESP.
  - W_RESP:
    - M_BVALID[g] = S_BVALID; S_BREADY = M_BREADY[g]; M_BRESP = S_BRESP.
    - On the B handshake: wr_ptr = g+1 (wrapping), clear the grant and done flags, go to W_IDLE.
- Read FSM:
  - R_IDLE: arbitrates M_ARVALID the same way using rd_ptr, then goes to R_ADDR.
  - R_ADDR: forwards AR; on the AR handshake goes to R_DATA.
  - R_DATA: forwards R to master g, with M_RDATA/M_RRESP = S_RDATA/S_RRESP. On the R handshake: rd_ptr = g+1, go to R_IDLE.
- Non-granted masters:
  - See READY = 0 and B/RVALID = 0.
  - Their AWVALID/ARVALID stay pending untouched; AXI requires them to remain asserted.
- Simultaneous events:
  - Read and write may be active concurrently, to the same or different masters.
  - Multiple requesters in IDLE resolve by pointer only.
  - A new grant is never issued in the same cycle as a completion; IDLE always lasts at least 1 cycle.
- Fairness: with all masters continuously requesting, grants rotate 0,1,…,N-1,0. No master waits more than NUM_MASTERS-1 transactions.
- No combinational path from S_*READY to S_*VALID.

Decomposition:
- axi4_lite_Defs gains:
  - AXI response constants OKAY=2'b00 and SLVERR=2'b10.
  - Typedef wr_state_t {W_IDLE, W_ADDR, W_RESP}.
  - Typedef rd_state_t {R_IDLE, R_ADDR, R_DATA}.
- One sub-module, rr_arbiter (request vector + pointer → one-hot grant + index, purely combinational), instantiated twice (write and read).

Test Plan:
- Single master 0 writes addr 0x0000_0010, data 0xDEAD_BEEF, strb 4'hF:
  - S_AWVALID rises 1 cycle after M_AWVALID[0].
  - Slave sees that exact addr/data.
  - M_BVALID[0] with BRESP=OKAY; wr_grant returns to 0.
- Masters 0 and 1 both assert ARVALID in the same cycle, from reset:
  - Master 0 is served first, then master 1.
  - Repeat with both requesting: master 1 is served before master 0 (pointer rotation).
- W before AW: master 1 drives WVALID 3 cycles before AWVALID, with the slave holding AWREADY low 2 cycles:
  - The data handshake completes first.
  - W_RESP is entered only after the AW handshake.
  - No duplicate W beat reaches the slave.
- Concurrent traffic: master 0 write to 0x20 while master 1 reads 0x20 with slave RDATA=0x1234_5678:
  - Both complete independently.
  - M_RVALID[0] is never asserted.
- Backpressure: M_BREADY[0] held low 5 cycles:
  - S_BREADY stays low and the FSM holds W_RESP.
  - Master 1's pending AWVALID is not granted until the B handshake.
- Reset mid-operation: assert ARESETN low while in W_ADDR (AW done, W pending):
  - All grants, valids and readies go to 0 immediately.
  - After release, the first request to be granted is master 0's.
